// File: rtl/decode_pkg.sv
// Shared widths and types for the 2-to-4 line decoder.
// Both the combinational core and the registered top import this package.
package decode_pkg;

  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 4;

  typedef logic [DEC_OUT_W-1:0] onehot4_t;

endpackage : decode_pkg

// File: rtl/decode_2to4_core.sv
// Combinational 2-to-4 decode: one-hot select code, all zero when disabled.
module decode_2to4_core
  import decode_pkg::*;
(
  input  logic [DEC_IN_W-1:0] a,
  input  logic                en,
  output onehot4_t            dec
);

  always_comb begin
    dec = '0;
    if (en) begin
      case (a)
        2'b00:   dec = 4'b0001;
        2'b01:   dec = 4'b0010;
        2'b10:   dec = 4'b0100;
        2'b11:   dec = 4'b1000;
        default: dec = 4'b0000;
      endcase
    end
  end

endmodule : decode_2to4_core

// File: rtl/decode_2to4.sv
// Registered 2-to-4 line decoder with active-high enable.
// OUT_REG selects a one-cycle async-reset output register or a plain wire.
module decode_2to4
  import decode_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DEC_IN_W-1:0]  a,
  input  logic                 en,
  output logic [DEC_OUT_W-1:0] out
);

  onehot4_t dec;

  decode_2to4_core u_core (
    .a   (a),
    .en  (en),
    .dec (dec)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      onehot4_t out_d;
      onehot4_t out_q;

      always_comb begin
        out_d = dec;
      end

      // Reset clears the output immediately so no stale select stays asserted.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign out = out_q;
    end else begin : g_out_comb
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign out = dec;
    end
  endgenerate

endmodule : decode_2to4

// File: tb/tb_decode_2to4.sv
// Bench for decode_2to4: a registered instance and a combinational instance
// share the same stimulus and are compared against a behavioural decode model.
module tb_decode_2to4;

  logic       clk;
  logic       rst_i;
  logic [1:0] a_i;
  logic       en_i;
  logic [3:0] out_r;
  logic [3:0] out_c;

  int checks;
  int failures;

  logic [3:0] exp_q[$];

  decode_2to4 #(.OUT_REG(1)) dut_reg (
    .clk   (clk),
    .reset (rst_i),
    .a     (a_i),
    .en    (en_i),
    .out   (out_r)
  );

  decode_2to4 #(.OUT_REG(0)) dut_comb (
    .clk   (clk),
    .reset (rst_i),
    .a     (a_i),
    .en    (en_i),
    .out   (out_c)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: output value is 2 raised to the select code when enabled.
  function automatic logic [3:0] ref_decode(input logic e, input logic [1:0] sel);
    int v;
    v = e ? (2 ** int'(sel)) : 0;
    return v[3:0];
  endfunction

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: check the registered output against the oldest expectation,
  // then apply new inputs and check the combinational instance at once.
  task automatic drive_cycle(input logic e, input logic [1:0] sel);
    logic [3:0] exp_now;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check_eq("reg_out", out_r, exp_q.pop_front());
    end
    check_eq("reg_onehot", {3'b000, $onehot0(out_r)}, 4'b0001);
    en_i = e;
    a_i  = sel;
    exp_now = ref_decode(e, sel);
    exp_q.push_back(exp_now);
    #1;
    check_eq("comb_out", out_c, exp_now);
  endtask

  task automatic hold(input logic e, input logic [1:0] sel, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_cycle(e, sel);
    end
  endtask

  // Assert reset between edges, expect an immediate clear, hold, then release.
  task automatic async_reset_and_release(input logic e, input logic [1:0] sel, input int cycles);
    @(posedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_clear", out_r, 4'b0000);
    exp_q.delete();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      en_i = e;
      a_i  = sel;
      #1;
      check_eq("rst_hold", out_r, 4'b0000);
      check_eq("rst_comb", out_c, ref_decode(e, sel));
    end
    @(negedge clk);
    check_eq("rst_before_release", out_r, 4'b0000);
    rst_i = 1'b0;
    en_i  = e;
    a_i   = sel;
    exp_q.push_back(ref_decode(e, sel));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    en_i  = 1'b0;
    a_i   = 2'b00;
    rst_i = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("reset_state", out_r, 4'b0000);
    rst_i = 1'b0;
    exp_q.push_back(ref_decode(1'b0, 2'b00));

    // disabled, then each code held for 200 ns
    hold(1'b0, 2'b00, 20);
    for (int s = 0; s < 4; s++) begin
      hold(1'b1, s[1:0], 20);
    end

    // enable drop and return with a=11
    hold(1'b1, 2'b11, 3);
    hold(1'b0, 2'b11, 3);
    hold(1'b1, 2'b11, 3);

    // en=0 dominates every code
    for (int s = 0; s < 4; s++) begin
      drive_cycle(1'b0, s[1:0]);
    end

    // async reset while out=0100, then restore
    hold(1'b1, 2'b10, 3);
    @(negedge clk);
    check_eq("pre_rst_0100", out_r, exp_q.pop_front());
    exp_q.push_back(ref_decode(1'b1, 2'b10));
    async_reset_and_release(1'b1, 2'b10, 2);
    hold(1'b1, 2'b10, 2);

    // exhaustive back-to-back sweep, two passes
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 8; c++) begin
        drive_cycle(c[2], c[1:0]);
      end
    end

    // random stimulus with an occasional mid-run reset
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if (i == 150) begin
        async_reset_and_release(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
      end
    end

    drive_cycle(1'b0, 2'b00);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      check_eq("final_drain", out_r, exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_decode_2to4
